// File: rtl/ts_pkg.sv
// ts_pkg: shared definitions for the TS mode controller.
//   mode_e        : per-channel mode encoding (IDLE/PASS/PLAY/REC)
//   cmd_t         : one resolved command (valid flag + target mode)
//   resolve_cmd   : collapses simultaneous command pulses, STOP > PASS > REC > PLAY
//   needs_resource: true for modes that reserve a shared engine (REC, PLAY)
package ts_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_PASS = 2'b01,
    MODE_PLAY = 2'b10,
    MODE_REC  = 2'b11
  } mode_e;

  typedef struct packed {
    logic  valid;
    mode_e mode;
  } cmd_t;

  // Priority order lives here so every channel resolves collisions identically.
  function automatic cmd_t resolve_cmd(input logic stop, input logic pass,
                                       input logic rec, input logic play);
    cmd_t c;
    c.valid = stop | pass | rec | play;
    if (stop) begin
      c.mode = MODE_IDLE;
    end else if (pass) begin
      c.mode = MODE_PASS;
    end else if (rec) begin
      c.mode = MODE_REC;
    end else if (play) begin
      c.mode = MODE_PLAY;
    end else begin
      c.mode = MODE_IDLE;
    end
    return c;
  endfunction

  function automatic logic needs_resource(input mode_e m);
    return (m == MODE_REC) || (m == MODE_PLAY);
  endfunction

endpackage

// File: rtl/ts_mode_ch.sv
// ts_mode_ch: one TS channel -- byte counter, current mode and pending command.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_byte_valid            : TS byte strobe
//   i_pkt_start             : current valid byte is the sync byte (packet byte 0)
//   i_cmd                   : resolved command for this cycle
//   i_grant                 : shared resource granted (only consulted for REC/PLAY)
//   o_state                 : current mode
//   o_pending, o_pend_mode  : command waiting for the packet boundary
//   o_switched, o_reject    : one-cycle status pulses
module ts_mode_ch
  import ts_pkg::*;
#(
  parameter int PKT_LEN = 188,
  parameter int CW      = $clog2(PKT_LEN)
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_byte_valid,
  input  logic  i_pkt_start,
  input  cmd_t  i_cmd,
  input  logic  i_grant,
  output mode_e o_state,
  output logic  o_pending,
  output mode_e o_pend_mode,
  output logic  o_switched,
  output logic  o_reject
);

  logic [CW-1:0] r_cnt;
  mode_e         r_state;
  logic          r_pend;
  mode_e         r_pend_mode;
  logic          r_switched;
  logic          r_reject;

  logic [CW-1:0] w_cnt_nx;
  mode_e         w_state_nx;
  logic          w_pend_nx;
  mode_e         w_pend_mode_nx;
  logic          w_reject_nx;
  logic          w_last;
  logic          w_boundary;
  logic          w_accept;

  // The counter holds the index of the next expected byte, so the last byte
  // of a packet is the one seen while it reads PKT_LEN-1.  A sync byte in
  // that slot is a resync, not a boundary.
  assign w_last     = (r_cnt == CW'(PKT_LEN - 1));
  assign w_boundary = i_byte_valid && w_last && !i_pkt_start;
  assign w_accept   = i_cmd.valid && (!needs_resource(i_cmd.mode) || i_grant);

  // Byte counter next value: sync byte loads 1, otherwise count and wrap.
  always_comb begin
    w_cnt_nx = r_cnt;
    if (i_byte_valid && i_pkt_start) begin
      w_cnt_nx = CW'(1);
    end else if (i_byte_valid) begin
      w_cnt_nx = w_last ? '0 : r_cnt + CW'(1);
    end else begin
      w_cnt_nx = r_cnt;
    end
  end

  // Mode/pending next value: immediate apply, defer to boundary, or no-op.
  always_comb begin
    w_state_nx     = r_state;
    w_pend_nx      = r_pend;
    w_pend_mode_nx = r_pend_mode;
    w_reject_nx    = i_cmd.valid && needs_resource(i_cmd.mode) && !i_grant;
    if (w_accept) begin
      if ((i_cmd.mode == MODE_IDLE) || (r_state == MODE_IDLE) || w_boundary) begin
        w_state_nx = i_cmd.mode;
        w_pend_nx  = 1'b0;
      end else if ((i_cmd.mode == r_state) && !r_pend) begin
        w_pend_nx = 1'b0;
      end else begin
        // Newest accepted command replaces whatever was waiting.
        w_pend_nx      = 1'b1;
        w_pend_mode_nx = i_cmd.mode;
      end
    end else if (w_boundary && r_pend) begin
      w_state_nx = r_pend_mode;
      w_pend_nx  = 1'b0;
    end else begin
      w_pend_nx = r_pend;
    end
  end

  // Channel registers; SWITCHED marks the cycle the new mode becomes visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_state     <= MODE_IDLE;
      r_pend      <= 1'b0;
      r_pend_mode <= MODE_IDLE;
      r_switched  <= 1'b0;
      r_reject    <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nx;
      r_state     <= w_state_nx;
      r_pend      <= w_pend_nx;
      r_pend_mode <= w_pend_mode_nx;
      r_switched  <= (w_state_nx != r_state);
      r_reject    <= w_reject_nx;
    end
  end

  assign o_state     = r_state;
  assign o_pending   = r_pend;
  assign o_pend_mode = r_pend_mode;
  assign o_switched  = r_switched;
  assign o_reject    = r_reject;

endmodule

// File: rtl/ts_mode_ctrl.sv
// ts_mode_ctrl: multi-channel TS mode controller with shared REC/PLAY engines.
//   CLOCK, RESET            : clock, asynchronous active-low reset
//   PASS/PLAY/REC/STOP      : per-channel command pulses
//   BYTE_VALID, PKT_START   : per-channel TS byte framing
//   STATE                   : per-channel mode, channel i at [2i+1:2i]
//   PENDING/SWITCHED/REJECT : per-channel status
//   REC_BUSY/REC_OWNER, PLAY_BUSY/PLAY_OWNER : shared engine reservations
module ts_mode_ctrl
  import ts_pkg::*;
#(
  parameter  int NUM_CH  = 2,
  parameter  int PKT_LEN = 188,
  parameter  int CW      = $clog2(PKT_LEN),
  localparam int OW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] PASS,
  input  logic [NUM_CH-1:0] PLAY,
  input  logic [NUM_CH-1:0] REC,
  input  logic [NUM_CH-1:0] STOP,
  input  logic [NUM_CH-1:0] BYTE_VALID,
  input  logic [NUM_CH-1:0] PKT_START,
  output logic [2*NUM_CH-1:0] STATE,
  output logic [NUM_CH-1:0] PENDING,
  output logic [NUM_CH-1:0] SWITCHED,
  output logic [NUM_CH-1:0] REJECT,
  output logic              REC_BUSY,
  output logic              PLAY_BUSY,
  output logic [OW-1:0]     REC_OWNER,
  output logic [OW-1:0]     PLAY_OWNER
);

  cmd_t              w_cmd   [NUM_CH];
  mode_e             w_state [NUM_CH];
  mode_e             w_pmode [NUM_CH];
  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_rec_grant;
  logic [NUM_CH-1:0] w_play_grant;
  logic [OW-1:0]     w_rec_gidx;
  logic [OW-1:0]     w_play_gidx;
  logic              w_rec_found;
  logic              w_play_found;
  logic              w_rec_hold;
  logic              w_play_hold;

  logic              r_rec_busy;
  logic              r_play_busy;
  logic [OW-1:0]     r_rec_owner;
  logic [OW-1:0]     r_play_owner;

  // Resolve per-channel command collisions before arbitration, so a REC or
  // PLAY masked by a higher-priority command never competes for an engine.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_cmd[i] = resolve_cmd(STOP[i], PASS[i], REC[i], PLAY[i]);
    end
  end

  // Engine arbitration (owner only when busy, else lowest index) and the
  // hold condition: owner still in, or waiting to enter, that mode.
  always_comb begin
    w_rec_grant  = '0;
    w_play_grant = '0;
    w_rec_gidx   = '0;
    w_play_gidx  = '0;
    w_rec_found  = 1'b0;
    w_play_found = 1'b0;
    w_rec_hold   = 1'b0;
    w_play_hold  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_cmd[i].valid && (w_cmd[i].mode == MODE_REC) && !w_rec_found &&
          (!r_rec_busy || (r_rec_owner == OW'(i)))) begin
        w_rec_grant[i] = 1'b1;
        w_rec_gidx     = OW'(i);
        w_rec_found    = 1'b1;
      end else begin
        w_rec_grant[i] = 1'b0;
      end
      if (w_cmd[i].valid && (w_cmd[i].mode == MODE_PLAY) && !w_play_found &&
          (!r_play_busy || (r_play_owner == OW'(i)))) begin
        w_play_grant[i] = 1'b1;
        w_play_gidx     = OW'(i);
        w_play_found    = 1'b1;
      end else begin
        w_play_grant[i] = 1'b0;
      end
      if (r_rec_owner == OW'(i) &&
          ((w_state[i] == MODE_REC) || (w_pend[i] && (w_pmode[i] == MODE_REC)))) begin
        w_rec_hold = 1'b1;
      end else begin
        w_rec_hold = w_rec_hold;
      end
      if (r_play_owner == OW'(i) &&
          ((w_state[i] == MODE_PLAY) || (w_pend[i] && (w_pmode[i] == MODE_PLAY)))) begin
        w_play_hold = 1'b1;
      end else begin
        w_play_hold = w_play_hold;
      end
    end
  end

  // Reservation registers: a fresh grant wins, otherwise hold or release.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_rec_busy   <= 1'b0;
      r_rec_owner  <= '0;
      r_play_busy  <= 1'b0;
      r_play_owner <= '0;
    end else begin
      if (w_rec_found) begin
        r_rec_busy  <= 1'b1;
        r_rec_owner <= w_rec_gidx;
      end else if (r_rec_busy && w_rec_hold) begin
        r_rec_busy  <= 1'b1;
      end else begin
        r_rec_busy  <= 1'b0;
        r_rec_owner <= '0;
      end
      if (w_play_found) begin
        r_play_busy  <= 1'b1;
        r_play_owner <= w_play_gidx;
      end else if (r_play_busy && w_play_hold) begin
        r_play_busy  <= 1'b1;
      end else begin
        r_play_busy  <= 1'b0;
        r_play_owner <= '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ts_mode_ch #(
      .PKT_LEN (PKT_LEN),
      .CW      (CW)
    ) u_ch (
      .i_clk        (CLOCK),
      .i_rst_n      (RESET),
      .i_byte_valid (BYTE_VALID[g]),
      .i_pkt_start  (PKT_START[g]),
      .i_cmd        (w_cmd[g]),
      .i_grant      (w_rec_grant[g] | w_play_grant[g]),
      .o_state      (w_state[g]),
      .o_pending    (w_pend[g]),
      .o_pend_mode  (w_pmode[g]),
      .o_switched   (SWITCHED[g]),
      .o_reject     (REJECT[g])
    );
    assign STATE[2*g +: 2] = w_state[g];
  end

  assign PENDING    = w_pend;
  assign REC_BUSY   = r_rec_busy;
  assign REC_OWNER  = r_rec_owner;
  assign PLAY_BUSY  = r_play_busy;
  assign PLAY_OWNER = r_play_owner;

endmodule

// File: tb/tb_ts_mode_ctrl.sv
// tb_ts_mode_ctrl: directed bench for ts_mode_ctrl (NUM_CH=2, PKT_LEN=188).
module tb_ts_mode_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] pass, play, rec, stop, bv, ps;
  logic [3:0] state;
  logic [1:0] pending, switched, reject;
  logic       rec_busy, play_busy;
  logic [0:0] rec_owner, play_owner;

  int n_vec = 0;
  int n_err = 0;

  ts_mode_ctrl #(.NUM_CH(2), .PKT_LEN(188)) dut (
    .CLOCK(clk), .RESET(rst_n),
    .PASS(pass), .PLAY(play), .REC(rec), .STOP(stop),
    .BYTE_VALID(bv), .PKT_START(ps),
    .STATE(state), .PENDING(pending), .SWITCHED(switched), .REJECT(reject),
    .REC_BUSY(rec_busy), .PLAY_BUSY(play_busy),
    .REC_OWNER(rec_owner), .PLAY_OWNER(play_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] p, input logic [1:0] r,
                       input logic [1:0] pl, input logic [1:0] s);
    pass = p; rec = r; play = pl; stop = s;
    tick();
    pass = 2'b00; rec = 2'b00; play = 2'b00; stop = 2'b00;
  endtask

  task automatic send_bytes(input int n, input logic [1:0] mask);
    bv = mask;
    repeat (n) tick();
    bv = 2'b00;
  endtask

  task automatic sync_byte(input logic [1:0] mask);
    bv = mask; ps = mask;
    tick();
    bv = 2'b00; ps = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++; if (state !== 4'b0000) begin n_err++; $display("FAIL reset_state: got %b want %b", state, 4'b0000); end
    n_vec++; if ({pending, switched, reject} !== 6'b000000) begin n_err++; $display("FAIL reset_flags: got %b want %b", {pending, switched, reject}, 6'b000000); end
    n_vec++; if ({rec_busy, play_busy, rec_owner, play_owner} !== 4'b0000) begin n_err++; $display("FAIL reset_busy: got %b want %b", {rec_busy, play_busy, rec_owner, play_owner}, 4'b0000); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rec_idle();
    pulse(2'b00, 2'b01, 2'b00, 2'b00);
    n_vec++; if (state !== 4'b0011) begin n_err++; $display("FAIL rec_idle_state: got %b want %b", state, 4'b0011); end
    n_vec++; if (switched !== 2'b01) begin n_err++; $display("FAIL rec_idle_switched: got %b want %b", switched, 2'b01); end
    n_vec++; if ({rec_busy, rec_owner} !== 2'b10) begin n_err++; $display("FAIL rec_idle_busy: got %b want %b", {rec_busy, rec_owner}, 2'b10); end
    tick();
    n_vec++; if (switched !== 2'b00) begin n_err++; $display("FAIL rec_idle_switch_pulse: got %b want %b", switched, 2'b00); end
  endtask

  task automatic test_pending_pass();
    sync_byte(2'b01);            // byte 0
    send_bytes(49, 2'b01);       // bytes 1..49
    bv = 2'b01;                  // byte 50 together with PASS
    pulse(2'b01, 2'b00, 2'b00, 2'b00);
    bv = 2'b00;
    n_vec++; if (pending !== 2'b01) begin n_err++; $display("FAIL pend_pass_pending: got %b want %b", pending, 2'b01); end
    n_vec++; if (state !== 4'b0011) begin n_err++; $display("FAIL pend_pass_hold: got %b want %b", state, 4'b0011); end
    send_bytes(136, 2'b01);      // bytes 51..186
    n_vec++; if (state !== 4'b0011) begin n_err++; $display("FAIL pend_pass_byte186: got %b want %b", state, 4'b0011); end
    send_bytes(1, 2'b01);        // byte 187: boundary
    n_vec++; if (state !== 4'b0001) begin n_err++; $display("FAIL pend_pass_applied: got %b want %b", state, 4'b0001); end
    n_vec++; if ({switched, pending} !== 4'b0100) begin n_err++; $display("FAIL pend_pass_flags: got %b want %b", {switched, pending}, 4'b0100); end
    tick();
    n_vec++; if ({rec_busy, rec_owner} !== 2'b00) begin n_err++; $display("FAIL pend_pass_release: got %b want %b", {rec_busy, rec_owner}, 2'b00); end
  endtask

  task automatic test_priority();
    pulse(2'b01, 2'b00, 2'b00, 2'b00);   // PASS while already PASS
    n_vec++; if ({state, switched, pending, reject} !== 10'b0001_00_00_00) begin n_err++; $display("FAIL noop_same_mode: got %b want %b", {state, switched, pending, reject}, 10'b0001_00_00_00); end
    pulse(2'b00, 2'b00, 2'b00, 2'b01);
    n_vec++; if ({state, switched} !== 6'b0000_01) begin n_err++; $display("FAIL stop_from_pass: got %b want %b", {state, switched}, 6'b0000_01); end
    pulse(2'b01, 2'b00, 2'b00, 2'b01);   // STOP beats PASS, already idle
    n_vec++; if ({state, switched} !== 6'b0000_00) begin n_err++; $display("FAIL prio_stop_pass: got %b want %b", {state, switched}, 6'b0000_00); end
    pulse(2'b01, 2'b01, 2'b01, 2'b00);   // PASS beats REC and PLAY
    n_vec++; if ({state, reject, rec_busy, play_busy} !== 8'b0001_00_0_0) begin n_err++; $display("FAIL prio_pass_rec_play: got %b want %b", {state, reject, rec_busy, play_busy}, 8'b0001_00_0_0); end
    pulse(2'b00, 2'b01, 2'b01, 2'b00);   // REC beats PLAY, deferred (mid-packet)
    n_vec++; if ({state, pending, rec_busy, play_busy} !== 8'b0001_01_1_0) begin n_err++; $display("FAIL prio_rec_play: got %b want %b", {state, pending, rec_busy, play_busy}, 8'b0001_01_1_0); end
    pulse(2'b00, 2'b00, 2'b00, 2'b01);
    tick();
  endtask

  task automatic test_contention();
    pulse(2'b00, 2'b11, 2'b00, 2'b00);
    n_vec++; if ({state, reject} !== 6'b0011_10) begin n_err++; $display("FAIL contend_grant: got %b want %b", {state, reject}, 6'b0011_10); end
    n_vec++; if ({rec_busy, rec_owner} !== 2'b10) begin n_err++; $display("FAIL contend_owner: got %b want %b", {rec_busy, rec_owner}, 2'b10); end
    tick();
    n_vec++; if (reject !== 2'b00) begin n_err++; $display("FAIL contend_reject_pulse: got %b want %b", reject, 2'b00); end
    pulse(2'b00, 2'b00, 2'b00, 2'b01);
    tick();
    n_vec++; if (rec_busy !== 1'b0) begin n_err++; $display("FAIL contend_release: got %b want %b", rec_busy, 1'b0); end
    pulse(2'b00, 2'b10, 2'b00, 2'b00);
    n_vec++; if ({state, rec_busy, rec_owner} !== 6'b1100_1_1) begin n_err++; $display("FAIL ch1_rec_owner: got %b want %b", {state, rec_busy, rec_owner}, 6'b1100_1_1); end
    pulse(2'b00, 2'b01, 2'b00, 2'b00);
    n_vec++; if ({state, reject, rec_owner} !== 7'b1100_01_1) begin n_err++; $display("FAIL rec_busy_reject: got %b want %b", {state, reject, rec_owner}, 7'b1100_01_1); end
    pulse(2'b00, 2'b00, 2'b00, 2'b10);
    tick();
  endtask

  task automatic test_stop_pending();
    pulse(2'b10, 2'b00, 2'b00, 2'b00);
    n_vec++; if (state !== 4'b0100) begin n_err++; $display("FAIL ch1_pass: got %b want %b", state, 4'b0100); end
    pulse(2'b00, 2'b00, 2'b10, 2'b00);
    n_vec++; if ({state, pending, play_busy, play_owner} !== 8'b0100_10_1_1) begin n_err++; $display("FAIL ch1_play_pending: got %b want %b", {state, pending, play_busy, play_owner}, 8'b0100_10_1_1); end
    pulse(2'b00, 2'b00, 2'b00, 2'b10);
    n_vec++; if ({state, pending, switched} !== 8'b0000_00_10) begin n_err++; $display("FAIL ch1_stop: got %b want %b", {state, pending, switched}, 8'b0000_00_10); end
    tick();
    n_vec++; if ({play_busy, play_owner} !== 2'b00) begin n_err++; $display("FAIL ch1_play_release: got %b want %b", {play_busy, play_owner}, 2'b00); end
  endtask

  task automatic test_resync();
    pulse(2'b00, 2'b00, 2'b01, 2'b00);
    n_vec++; if ({state, play_busy} !== 5'b0010_1) begin n_err++; $display("FAIL resync_play: got %b want %b", {state, play_busy}, 5'b0010_1); end
    sync_byte(2'b01);
    send_bytes(99, 2'b01);       // counter now 100
    pulse(2'b01, 2'b00, 2'b00, 2'b00);
    n_vec++; if ({state, pending} !== 6'b0010_01) begin n_err++; $display("FAIL resync_pending: got %b want %b", {state, pending}, 6'b0010_01); end
    sync_byte(2'b01);            // resync: counter back to 1
    send_bytes(186, 2'b01);      // old boundary passed long ago
    n_vec++; if ({state, pending} !== 6'b0010_01) begin n_err++; $display("FAIL resync_not_yet: got %b want %b", {state, pending}, 6'b0010_01); end
    send_bytes(1, 2'b01);        // 187th byte after resync
    n_vec++; if ({state, pending, switched} !== 8'b0001_00_01) begin n_err++; $display("FAIL resync_applied: got %b want %b", {state, pending, switched}, 8'b0001_00_01); end
    tick();
    n_vec++; if (play_busy !== 1'b0) begin n_err++; $display("FAIL resync_release: got %b want %b", play_busy, 1'b0); end
    pulse(2'b00, 2'b00, 2'b00, 2'b01);
  endtask

  task automatic test_reset_mid();
    pulse(2'b10, 2'b01, 2'b00, 2'b00);
    pulse(2'b00, 2'b00, 2'b10, 2'b00);
    n_vec++; if ({state, pending, rec_busy, play_busy} !== 8'b0111_10_1_1) begin n_err++; $display("FAIL rst_mid_setup: got %b want %b", {state, pending, rec_busy, play_busy}, 8'b0111_10_1_1); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({state, pending, switched, reject, rec_busy, play_busy, rec_owner, play_owner} !== 14'b0) begin n_err++; $display("FAIL rst_mid_async: got %b want %b", {state, pending, switched, reject, rec_busy, play_busy, rec_owner, play_owner}, 14'b0); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if ({state, switched, pending} !== 8'b0) begin n_err++; $display("FAIL rst_mid_quiet%0d: got %b want %b", i, {state, switched, pending}, 8'b0); end
    end
    pulse(2'b01, 2'b00, 2'b00, 2'b00);
    n_vec++; if ({state, switched} !== 6'b0001_01) begin n_err++; $display("FAIL rst_mid_resume: got %b want %b", {state, switched}, 6'b0001_01); end
  endtask

  initial begin
    rst_n = 1'b0;
    pass = 2'b00; play = 2'b00; rec = 2'b00; stop = 2'b00; bv = 2'b00; ps = 2'b00;
    test_reset();
    test_rec_idle();
    test_pending_pass();
    test_priority();
    test_contention();
    test_stop_pending();
    test_resync();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ts_mode_ctrl.md
TS_MODE_CTRL -- requirements
Module: ts_mode_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent TS channels (1..8).
REQ-002 SHALL have parameter PKT_LEN, default 188, TS packet length in bytes.
REQ-003 SHALL have parameter CW, default $clog2(PKT_LEN), byte-counter width.
REQ-004 SHALL have port CLOCK  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port PASS  in  NUM_CH  per-channel pass-through command pulse.
REQ-007 SHALL have port PLAY  in  NUM_CH  per-channel playback command pulse.
REQ-008 SHALL have port REC  in  NUM_CH  per-channel record command pulse.
REQ-009 SHALL have port STOP  in  NUM_CH  per-channel return-to-idle command pulse.
REQ-010 SHALL have port BYTE_VALID  in  NUM_CH  per-channel TS byte strobe.
REQ-011 SHALL have port PKT_START  in  NUM_CH  marks the current valid byte as packet byte 0 (sync byte).
REQ-012 SHALL have port STATE  out  2*NUM_CH  per-channel mode, channel i at bits [2i+1:2i].
REQ-013 SHALL have port PENDING  out  NUM_CH  command accepted, waiting for packet boundary.
REQ-014 SHALL have port SWITCHED  out  NUM_CH  one-cycle pulse when a new mode takes effect.
REQ-015 SHALL have port REJECT  out  NUM_CH  one-cycle pulse when a command is refused.
REQ-016 SHALL have ports REC_BUSY/PLAY_BUSY  out  1 each  shared record/playback resource reserved.
REQ-017 SHALL have ports REC_OWNER/PLAY_OWNER  out  $clog2(NUM_CH) (min 1)  reserving channel index, 0 when not busy.

Function
REQ-018 STATE encoding SHALL be IDLE=2'b00, PASS=2'b01, PLAY=2'b10, REC=2'b11.
REQ-019 Simultaneous commands on one channel SHALL resolve by priority STOP > PASS > REC > PLAY; lower ones are ignored without REJECT.
REQ-020 Byte counter SHALL load 1 on BYTE_VALID&PKT_START, increment on BYTE_VALID otherwise, and wrap PKT_LEN-1 -> 0.
REQ-021 Packet boundary SHALL be the cycle with BYTE_VALID and counter==PKT_LEN-1 and no PKT_START.
REQ-022 Command to a channel in IDLE, or coinciding with its boundary, SHALL apply at that edge: STATE updates next cycle, SWITCHED pulses same cycle as STATE change.
REQ-023 Otherwise the command SHALL be stored as pending (PENDING=1 next cycle) and applied at the next boundary; a newer accepted command SHALL overwrite the pending one.
REQ-024 STOP SHALL always apply immediately, clearing any pending command.
REQ-025 Command equal to the current STATE with nothing pending SHALL be a no-op (no SWITCHED, no REJECT).
REQ-026 REC SHALL be accepted only if REC_BUSY=0 or REC_OWNER equals the requester; PLAY likewise with PLAY_BUSY.
REQ-027 Simultaneous REC (or PLAY) requests from several channels with the resource free SHALL grant the lowest index; the others pulse REJECT next cycle.
REQ-028 A reservation SHALL hold while the owner's STATE or pending mode is that mode, and release the cycle after neither is.
REQ-029 A PKT_START arriving mid-packet SHALL resynchronise the counter without applying pending commands.

Reset
REQ-030 RESET low SHALL asynchronously force STATE=IDLE, counters=0, PENDING=0, SWITCHED=0, REJECT=0, BUSY=0, OWNER=0 for all channels.
REQ-031 Reset assertion mid-packet or with commands pending SHALL discard them; operation resumes on the first edge after release.

Structure
REQ-032 Mode encoding constants and the priority order SHALL live in shared package ts_pkg.
REQ-033 Per-channel counter, pending register and state SHALL be sub-module ts_mode_ch, instantiated NUM_CH times; arbitration and ownership SHALL sit at top level.

Verification
REQ-034 Reset release, ch0 REC pulse while IDLE -> STATE[1:0]=11 and SWITCHED[0]=1 one cycle later, REC_BUSY=1, REC_OWNER=0.
REQ-035 ch0 in REC, PASS at packet byte 50 -> PENDING[0]=1, STATE stays 11 until byte 187 accepted, then 01, REC_BUSY=0 next cycle.
REQ-036 ch0 and ch1 REC same cycle from IDLE -> ch0 STATE=11, REJECT[1]=1, ch1 STATE unchanged 00.
REQ-037 ch1 pending PLAY then STOP before boundary -> STATE=00 next cycle, PENDING[1]=0, PLAY_BUSY=0.
REQ-038 PKT_START at byte 100 with pending PASS -> counter=1, PASS applied only after 187 further valid bytes.
REQ-039 RESET asserted with ch0 REC and ch1 pending PLAY -> all outputs 0 immediately, no SWITCHED after release.
